// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares one framebuffer write port between the pixel stream and a full-screen clear sweep.
// Optional FB_STATS_EN adds a saturating pix_count of retired pixel writes.
module fb_write_arbiter #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int ADDR_BITS  = 19,
  parameter int COLOR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  input  logic [COLOR_BITS-1:0] clear_color,
  output logic                  clear_done,
  input  logic                  pix_valid,
  input  logic [X_BITS-1:0]     pix_x,
  input  logic [Y_BITS-1:0]     pix_y,
  input  logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_ready,
  output logic                  fb_we,
  output logic [ADDR_BITS-1:0]  fb_addr,
  output logic [COLOR_BITS-1:0] fb_wdata,
  input  logic                  fb_ack,
  output logic                  busy
`ifdef FB_STATS_EN
  ,
  output logic [31:0]           pix_count
`endif
);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CLEAR      = 2'd1;
  localparam logic [1:0] CLEAR_WAIT = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_WIDTH * FB_HEIGHT - 1);
  logic [1:0]            state_q, state_d;
  logic                  fb_we_q, fb_we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, cnt_q, cnt_d;
  logic [COLOR_BITS-1:0] wdata_q, wdata_d, color_q, color_d;
  logic                  slot_free, pix_load, clr_acc, clr_load;
  always_comb begin
    slot_free = !fb_we_q || fb_ack;
    pix_ready = !rst && state_q == IDLE && slot_free && !clear_start;
    pix_load  = pix_valid && pix_ready && 32'(pix_x) < FB_WIDTH && 32'(pix_y) < FB_HEIGHT;
    clr_acc   = state_q == IDLE && clear_start;
    clr_load  = state_q == CLEAR && slot_free;
    fb_we_d   = pix_load || clr_load || (fb_we_q && !fb_ack);
    addr_d    = pix_load ? ADDR_BITS'(pix_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(pix_x)
              : clr_load ? cnt_q : addr_q;
    wdata_d   = pix_load ? pix_color : clr_load ? color_q : wdata_q;
    cnt_d     = clr_acc ? '0 : clr_load ? cnt_q + ADDR_BITS'(1) : cnt_q;
    color_d   = clr_acc ? clear_color : color_q;
    state_d   = clr_acc ? CLEAR
              : (clr_load && cnt_q == LAST_ADDR) ? CLEAR_WAIT
              : (state_q == CLEAR_WAIT && fb_ack) ? DONE
              : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fb_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      fb_we_q <= fb_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end
  assign fb_we      = fb_we_q;
  assign fb_addr    = addr_q;
  assign fb_wdata   = wdata_q;
  assign clear_done = state_q == DONE;
  assign busy       = state_q != IDLE || fb_we_q;
`ifdef FB_STATS_EN
  // slot_pix_q marks the occupied slot as a pixel write so clear writes are not counted
  logic        slot_pix_q, slot_pix_d;
  logic [31:0] count_q, count_d;
  always_comb begin
    slot_pix_d = pix_load ? 1'b1 : clr_load ? 1'b0 : slot_pix_q;
    count_d    = clr_acc ? '0
               : (fb_we_q && fb_ack && slot_pix_q && count_q != '1) ? count_q + 32'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_pix_q <= 1'b0;
      count_q    <= '0;
    end else begin
      slot_pix_q <= slot_pix_d;
      count_q    <= count_d;
    end
  end
  assign pix_count = count_q;
`endif
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single framebuffer write port. Shares it between two requesters: the rasterizer pixel stream (Bresenham output) and a built-in full-screen clear sweep.
- The rasterizer controller fires clear_start from its CLEAR state and waits for clear_done before starting SETUP1.
- Converts (x,y) to linear address y*FB_WIDTH+x, clips off-screen pixels, and holds writes stable under memory backpressure.

Parameters:
- FB_WIDTH, 640, pixels per row
- FB_HEIGHT, 480, rows
- X_BITS, 10, pix_x width
- Y_BITS, 9, pix_y width
- ADDR_BITS, 19, fb_addr width; must satisfy 2^ADDR_BITS >= FB_WIDTH*FB_HEIGHT
- COLOR_BITS, 8, pixel data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear_start  in  1  begin full-screen clear; single-cycle pulse
- clear_color  in  COLOR_BITS  fill value, sampled on the accepted clear_start
- clear_done  out  1  one-cycle pulse when the last clear write is acknowledged
- pix_valid  in  1  pixel request
- pix_x  in  X_BITS  pixel column
- pix_y  in  Y_BITS  pixel row
- pix_color  in  COLOR_BITS  pixel value
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- fb_we  out  1  write request to framebuffer
- fb_addr  out  ADDR_BITS  write address
- fb_wdata  out  COLOR_BITS  write data
- fb_ack  in  1  framebuffer accepts the current write this cycle
- busy  out  1  high when state != IDLE or fb_we is high

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; fb_we, fb_addr, fb_wdata, clear_done, clear counter and latched colour all 0.
  - Any pending write is discarded. Reset mid-clear aborts the clear and no clear_done is issued.
- Output register:
  - fb_we/fb_addr/fb_wdata form one registered slot. slot_free = !fb_we || fb_ack.
  - While fb_we && !fb_ack, fb_addr and fb_wdata hold stable.
  - If slot_free and nothing is loaded this cycle, fb_we drops to 0 on the next edge.
- States:
  - IDLE, CLEAR, CLEAR_WAIT, DONE.
- IDLE:
  - pix_ready = slot_free && !clear_start.
  - Pixel accepted at edge t → fb_we=1, fb_addr=pix_y*FB_WIDTH+pix_x, fb_wdata=pix_color at t+1. Latency 1 cycle.
  - Clipping: an accepted pixel with pix_x>=FB_WIDTH or pix_y>=FB_HEIGHT is consumed with no write; fb_we behaves as if no pixel was loaded.
  - clear_start → CLEAR. Latch clear_color; counter=0. Clear wins over a simultaneous pix_valid: pix_ready=0 that cycle.
- CLEAR:
  - pix_ready=0.
  - When slot_free: load fb_addr=counter, fb_wdata=latched colour, fb_we=1, counter++.
  - A pixel write still pending on entry retires first.
  - On loading address FB_WIDTH*FB_HEIGHT-1 → CLEAR_WAIT.
- CLEAR_WAIT:
  - pix_ready=0. On fb_ack → DONE.
- DONE:
  - clear_done=1 for exactly one cycle, pix_ready=0 → IDLE.
- clear_start outside IDLE is ignored.
- Address arithmetic:
  - Computed at ADDR_BITS width with the multiply zero-extended; no wrap inside the legal range.
  - Clear counter is ADDR_BITS wide.

Optional Feature:
- Macro FB_STATS_EN.
- When defined: adds output pix_count (32 bits). It increments on each retired pixel write (fb_we && fb_ack, slot loaded from the pixel path). Clipped pixels and clear writes are not counted. Reset to 0 by rst and by an accepted clear_start. Saturates at 2^32-1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use FB_WIDTH=4, FB_HEIGHT=3, ADDR_BITS=4.
1. Reset: rst high 2 cycles with pix_valid=1 → fb_we=0, pix_ready=0 during reset, busy=0, clear_done=0; after release pix_ready=1.
2. Single pixel (2,1,0x5A), fb_ack=1 → next cycle fb_we=1, fb_addr=6, fb_wdata=0x5A; following cycle fb_we=0.
3. Backpressure: pixel (1,1,0x33) with fb_ack=0 for 3 cycles → fb_addr=5 and fb_wdata=0x33 held for 3 cycles, pix_ready=0; a second pixel (0,2) is accepted only on the ack cycle and appears as fb_addr=8.
4. Clear: clear_start with clear_color=0x11, fb_ack=1 → 12 writes, fb_addr 0..11, all data 0x11. clear_done is a single pulse one cycle after the ack of addr 11. pix_ready=0 from clear_start through DONE.
5. Clipping: pixels (4,0) and (0,3) accepted with no fb_we; pixel (3,2,0x7E) → fb_addr=11. With FB_STATS_EN, pix_count=1.
6. Contention: clear_start and pix_valid in the same cycle → pixel not accepted; clear runs. Then assert rst after 5 clear writes → fb_we=0, state IDLE, no clear_done pulse.
